// File: rtl/riscv_hwloop_regs.sv
// -----------------------------------------------------------------------------
// riscv_hwloop_regs
// Hardware-loop register file: start address, end address and iteration
// counter for each of N_REGS loops. Written by the ID stage (lp.* / CSR),
// decremented on request of the downstream hwloop controller. Decrement
// requests that arrive while the ID stage is stalled are held as "pending"
// and applied on the first cycle the stage advances.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   hwlp_start_data_i     start address write data
//   hwlp_end_data_i       end address write data
//   hwlp_cnt_data_i       counter write data
//   hwlp_we_i[2:0]        write enables {counter, end, start}
//   hwlp_regid_i          loop index for writes (out-of-range -> ignored)
//   valid_i               ID stage advancing this cycle
//   hwlp_dec_cnt_i        per-loop decrement requests
//   hwlp_start_addr_o     flattened N_REGS x 32 start addresses
//   hwlp_end_addr_o       flattened N_REGS x 32 end addresses
//   hwlp_counter_o        flattened N_REGS x 32 counters
//   hwlp_dec_cnt_id_o     per-loop decrement in flight
//
// Optional feature (macro HWLP_READ_PORT_EN):
//   hwlp_rd_regid_i, hwlp_rd_sel_i, hwlp_rd_data_o -- combinational CSR read
//   of the stored values (00 start, 01 end, 10 counter, 11 zero).
// -----------------------------------------------------------------------------
module riscv_hwloop_regs #(
  parameter int unsigned N_REGS     = 2,
  parameter int unsigned N_REG_BITS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              hwlp_start_data_i,
  input  logic [31:0]              hwlp_end_data_i,
  input  logic [31:0]              hwlp_cnt_data_i,
  input  logic [2:0]               hwlp_we_i,
  input  logic [N_REG_BITS-1:0]    hwlp_regid_i,
  input  logic                     valid_i,
  input  logic [N_REGS-1:0]        hwlp_dec_cnt_i,
`ifdef HWLP_READ_PORT_EN
  input  logic [N_REG_BITS-1:0]    hwlp_rd_regid_i,
  input  logic [1:0]               hwlp_rd_sel_i,
  output logic [31:0]              hwlp_rd_data_o,
`endif
  output logic [N_REGS*32-1:0]     hwlp_start_addr_o,
  output logic [N_REGS*32-1:0]     hwlp_end_addr_o,
  output logic [N_REGS*32-1:0]     hwlp_counter_o,
  output logic [N_REGS-1:0]        hwlp_dec_cnt_id_o
);

  localparam int unsigned DW = 32;

  logic [DW-1:0]     start_q [N_REGS];
  logic [DW-1:0]     start_d [N_REGS];
  logic [DW-1:0]     end_q   [N_REGS];
  logic [DW-1:0]     end_d   [N_REGS];
  logic [DW-1:0]     cnt_q   [N_REGS];
  logic [DW-1:0]     cnt_d   [N_REGS];
  logic [N_REGS-1:0] pend_q;
  logic [N_REGS-1:0] pend_d;

  // Next-state: writes, collision priority, stall capture and saturating decrement
  always_comb begin
    logic wr_hit;
    logic eff_dec;
    pend_d = pend_q;
    wr_hit = 1'b0;
    eff_dec = 1'b0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      start_d[i] = start_q[i];
      end_d[i]   = end_q[i];
      cnt_d[i]   = cnt_q[i];

      wr_hit  = (DW'(hwlp_regid_i) == DW'(i));
      eff_dec = hwlp_dec_cnt_i[i] | pend_q[i];

      if (wr_hit && hwlp_we_i[0]) start_d[i] = hwlp_start_data_i;
      if (wr_hit && hwlp_we_i[1]) end_d[i]   = hwlp_end_data_i;

      // Counter write beats any decrement on the same loop and drops it
      if (wr_hit && hwlp_we_i[2]) begin
        cnt_d[i]  = hwlp_cnt_data_i;
        pend_d[i] = 1'b0;
      end else if (valid_i) begin
        if (eff_dec && (cnt_q[i] != '0)) cnt_d[i] = cnt_q[i] - DW'(1);
        pend_d[i] = 1'b0;
      end else begin
        pend_d[i] = eff_dec;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_REGS; i++) begin
        start_q[i] <= '0;
        end_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REGS; i++) begin
        start_q[i] <= start_d[i];
        end_q[i]   <= end_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pend_q <= pend_d;
    end
  end

  // Flatten register arrays onto the output buses
  for (genvar g = 0; g < N_REGS; g++) begin : g_out
    assign hwlp_start_addr_o[g*DW +: DW] = start_q[g];
    assign hwlp_end_addr_o[g*DW +: DW]   = end_q[g];
    assign hwlp_counter_o[g*DW +: DW]    = cnt_q[g];
  end
  assign hwlp_dec_cnt_id_o = pend_q;

`ifdef HWLP_READ_PORT_EN
  // CSR read mux; reflects stored state only, out-of-range index reads zero
  always_comb begin
    hwlp_rd_data_o = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      if (DW'(hwlp_rd_regid_i) == DW'(i)) begin
        case (hwlp_rd_sel_i)
          2'b00:   hwlp_rd_data_o = start_q[i];
          2'b01:   hwlp_rd_data_o = end_q[i];
          2'b10:   hwlp_rd_data_o = cnt_q[i];
          default: hwlp_rd_data_o = '0;
        endcase
      end
    end
  end
`endif

endmodule

// File: tb/tb_riscv_hwloop_regs.sv
module tb_riscv_hwloop_regs;

  localparam int unsigned NR = 2;
  localparam int unsigned NB = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [31:0]     sd = '0, ed = '0, cd = '0;
  logic [2:0]      we = '0;
  logic [NB-1:0]   regid = '0;
  logic            valid = 1'b0;
  logic [NR-1:0]   dec = '0;
  logic [NR*32-1:0] start_o, end_o, cnt_o;
  logic [NR-1:0]   pend_o;
`ifdef HWLP_READ_PORT_EN
  logic [NB-1:0]   rd_regid = '0;
  logic [1:0]      rd_sel = '0;
  logic [31:0]     rd_data;
`endif

  int n_checks = 0;
  int n_pass = 0;

  // Reference model state
  logic [31:0] m_start [NR];
  logic [31:0] m_end   [NR];
  logic [31:0] m_cnt   [NR];
  logic        m_pend  [NR];

  riscv_hwloop_regs #(.N_REGS(NR), .N_REG_BITS(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .hwlp_start_data_i(sd), .hwlp_end_data_i(ed), .hwlp_cnt_data_i(cd),
    .hwlp_we_i(we), .hwlp_regid_i(regid), .valid_i(valid),
    .hwlp_dec_cnt_i(dec),
`ifdef HWLP_READ_PORT_EN
    .hwlp_rd_regid_i(rd_regid), .hwlp_rd_sel_i(rd_sel), .hwlp_rd_data_o(rd_data),
`endif
    .hwlp_start_addr_o(start_o), .hwlp_end_addr_o(end_o),
    .hwlp_counter_o(cnt_o), .hwlp_dec_cnt_id_o(pend_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_start[i] = '0; m_end[i] = '0; m_cnt[i] = '0; m_pend[i] = 1'b0;
    end
  endtask

  // One clock of the architectural behaviour, from the current inputs
  task automatic model_step();
    int id;
    bool_loop: for (int i = 0; i < NR; i++) begin
      bit want_dec;
      bit hit;
      id = int'(regid);
      hit = (id == i);
      want_dec = dec[i] || m_pend[i];
      if (hit && we[0]) m_start[i] = sd;
      if (hit && we[1]) m_end[i] = ed;
      if (hit && we[2]) begin
        m_cnt[i] = cd;
        m_pend[i] = 1'b0;
      end else if (valid) begin
        if (want_dec && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
        m_pend[i] = 1'b0;
      end else begin
        m_pend[i] = want_dec;
      end
    end
  endtask

  function automatic logic [NR*96+NR-1:0] exp_all();
    logic [NR*32-1:0] s, e, c;
    logic [NR-1:0] p;
    for (int i = 0; i < NR; i++) begin
      s[i*32 +: 32] = m_start[i];
      e[i*32 +: 32] = m_end[i];
      c[i*32 +: 32] = m_cnt[i];
      p[i] = m_pend[i];
    end
    return {s, e, c, p};
  endfunction

  // Advance one cycle: model uses inputs present at the edge; sample #1 later
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; dec = '0; valid = 1'b0; regid = '0;
  endtask

  task automatic wr_cnt(input int id, input logic [31:0] v);
    we = 3'b100; regid = NB'(id); cd = v; dec = '0; valid = 1'b0;
    step();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    n_checks++;
    if ({start_o, end_o, cnt_o, pend_o} !== exp_all())
      $display("FAIL reset_hold: got %h want %h", {start_o, end_o, cnt_o, pend_o}, exp_all());
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    step();
    n_checks++;
    if ({start_o, end_o, cnt_o, pend_o} !== '0)
      $display("FAIL reset_release: got %h want 0", {start_o, end_o, cnt_o, pend_o});
    else n_pass++;
  endtask

  task automatic test_write();
    we = 3'b111; regid = 1; sd = 32'h100; ed = 32'h120; cd = 32'd5;
    step();
    idle();
    n_checks++;
    if ({start_o[63:32], end_o[63:32], cnt_o[63:32]} !== {32'h100, 32'h120, 32'd5})
      $display("FAIL write_loop1: got %h %h %h want 100 120 5", start_o[63:32], end_o[63:32], cnt_o[63:32]);
    else n_pass++;
    n_checks++;
    if ({start_o[31:0], end_o[31:0], cnt_o[31:0]} !== 96'h0)
      $display("FAIL write_loop0_untouched: got %h %h %h want 0", start_o[31:0], end_o[31:0], cnt_o[31:0]);
    else n_pass++;
`ifdef HWLP_READ_PORT_EN
    rd_regid = 1; rd_sel = 2'b01; #1;
    n_checks++;
    if (rd_data !== 32'h120) $display("FAIL rd_end1: got %h want 120", rd_data); else n_pass++;
    rd_sel = 2'b11; #1;
    n_checks++;
    if (rd_data !== 32'h0) $display("FAIL rd_sel11: got %h want 0", rd_data); else n_pass++;
    rd_regid = 2; rd_sel = 2'b00; #1;
    n_checks++;
    if (rd_data !== 32'h0) $display("FAIL rd_oor: got %h want 0", rd_data); else n_pass++;
    rd_regid = 1; rd_sel = 2'b10; #1;
    n_checks++;
    if (rd_data !== 32'd5) $display("FAIL rd_cnt1: got %h want 5", rd_data); else n_pass++;
`endif
  endtask

  task automatic test_dec_valid();
    wr_cnt(0, 32'd3);
    dec = 2'b01; valid = 1'b1;
    step();
    idle();
    n_checks++;
    if (cnt_o[31:0] !== 32'd2 || pend_o !== 2'b00)
      $display("FAIL dec_valid: got cnt0=%0d pend=%b want 2 00", cnt_o[31:0], pend_o);
    else n_pass++;
  endtask

  task automatic test_stall();
    wr_cnt(0, 32'd3);
    for (int c = 0; c < 3; c++) begin
      dec = (c == 0) ? 2'b01 : 2'b00; valid = 1'b0;
      step();
      n_checks++;
      if (pend_o !== 2'b01 || cnt_o[31:0] !== 32'd3)
        $display("FAIL stall_pend_c%0d: got pend=%b cnt0=%0d want 01 3", c, pend_o, cnt_o[31:0]);
      else n_pass++;
    end
    dec = 2'b00; valid = 1'b1;
    step();
    idle();
    n_checks++;
    if (pend_o !== 2'b00 || cnt_o[31:0] !== 32'd2)
      $display("FAIL stall_apply: got pend=%b cnt0=%0d want 00 2", pend_o, cnt_o[31:0]);
    else n_pass++;
  endtask

  task automatic test_collision_underflow();
    wr_cnt(1, 32'd4);
    we = 3'b100; regid = 0; cd = 32'd7; dec = 2'b11; valid = 1'b1;
    step();
    idle();
    n_checks++;
    if (cnt_o !== {32'd3, 32'd7})
      $display("FAIL collision: got %h want 00000003_00000007", cnt_o);
    else n_pass++;
    wr_cnt(0, 32'd0);
    dec = 2'b01; valid = 1'b1;
    step();
    idle();
    n_checks++;
    if (cnt_o[31:0] !== 32'd0)
      $display("FAIL underflow: got %h want 0", cnt_o[31:0]);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    we = 3'b111; regid = 2; sd = 32'hdead; ed = 32'hbeef; cd = 32'd9;
    step();
    regid = 3;
    step();
    idle();
    n_checks++;
    if ({start_o, end_o, cnt_o, pend_o} !== exp_all())
      $display("FAIL oor_write: got %h want %h", {start_o, end_o, cnt_o, pend_o}, exp_all());
    else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      we    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      regid = NB'($urandom);
      sd    = $urandom; ed = $urandom;
      cd    = 32'($urandom_range(0, 4));
      valid = 1'($urandom);
      dec   = NR'($urandom);
      step();
      n_checks++;
      if ({start_o, end_o, cnt_o, pend_o} !== exp_all()) begin
        if (errs < 5)
          $display("FAIL random_c%0d: got %h want %h", c, {start_o, end_o, cnt_o, pend_o}, exp_all());
        errs++;
      end else n_pass++;
    end
    idle();
  endtask

  task automatic test_reset_mid();
    wr_cnt(0, 32'd6);
    wr_cnt(1, 32'd2);
    dec = 2'b01; valid = 1'b0;
    step();
    idle();
    n_checks++;
    if (pend_o !== 2'b01) $display("FAIL midrst_pre: got pend=%b want 01", pend_o); else n_pass++;
    @(negedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({cnt_o, pend_o} !== '0)
      $display("FAIL midrst_clear: got %h want 0", {cnt_o, pend_o});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    step();
    n_checks++;
    if ({start_o, end_o, cnt_o, pend_o} !== exp_all())
      $display("FAIL midrst_after: got %h want %h", {start_o, end_o, cnt_o, pend_o}, exp_all());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_dec_valid();
    test_stall();
    test_collision_underflow();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
